// File: rtl/aes_round_ctrl.sv
// Round controller for a round-based AES-128 datapath: one LOAD cycle, NR ROUND
// cycles, then a one-cycle DONE pulse. Every output comes straight from a register.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       en,
    output logic       load,
    output logic       key_load,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       last_round,
    output logic       done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] NR_L      = 4'(NR);
    localparam logic [7:0] RCON_INIT = 8'h01;

    // GF(2^8) doubling used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    logic [1:0] state_r, state_s;
    logic [3:0] round_r, round_s;
    logic [7:0] rcon_r, rcon_s;
    logic       busy_r, en_r, load_r, key_load_r, last_round_r, done_r;
    logic       busy_s, load_s, last_round_s, done_s;

    // Next state, round index and round constant; abort wins over start everywhere.
    always_comb begin
        state_s = state_r;
        round_s = round_r;
        rcon_s  = rcon_r;
        case (state_r)
            IDLE, DONE: begin
                round_s = 4'd0;
                rcon_s  = RCON_INIT;
                if (start && !abort) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                rcon_s = RCON_INIT;
                if (abort) begin
                    state_s = IDLE;
                    round_s = 4'd0;
                end else begin
                    state_s = ROUND;
                    round_s = 4'd1;
                end
            end
            ROUND: begin
                if (abort || (round_r == NR_L)) begin
                    state_s = abort ? IDLE : DONE;
                    round_s = 4'd0;
                    rcon_s  = RCON_INIT;
                end else begin
                    state_s = ROUND;
                    round_s = round_r + 4'd1;
                    rcon_s  = xtime(rcon_r);
                end
            end
            default: begin
                state_s = IDLE;
                round_s = 4'd0;
                rcon_s  = RCON_INIT;
            end
        endcase
    end

    // Output values decoded from the upcoming state so they land in registers.
    always_comb begin
        busy_s       = (state_s == LOAD) || (state_s == ROUND);
        load_s       = (state_s == LOAD);
        last_round_s = (state_s == ROUND) && (round_s == NR_L);
        done_s       = (state_s == DONE);
    end

    // State and output registers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_r      <= IDLE;
            round_r      <= 4'd0;
            rcon_r       <= RCON_INIT;
            busy_r       <= 1'b0;
            en_r         <= 1'b0;
            load_r       <= 1'b0;
            key_load_r   <= 1'b0;
            last_round_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            round_r      <= round_s;
            rcon_r       <= rcon_s;
            busy_r       <= busy_s;
            en_r         <= busy_s;
            load_r       <= load_s;
            key_load_r   <= load_s;
            last_round_r <= last_round_s;
            done_r       <= done_s;
        end
    end

    assign busy       = busy_r;
    assign en         = en_r;
    assign load       = load_r;
    assign key_load   = key_load_r;
    assign round      = round_r;
    assign rcon       = rcon_r;
    assign last_round = last_round_r;
    assign done       = done_r;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round controller for the round-based unprotected AES-128 netlist in the NanGate45 flow. It accepts a start request and runs a one-cycle load phase followed by NR round cycles. During those cycles it drives the datapath register enables, the plaintext/key load selects, the round index, the round constant and the last-round flag. It then pulses `done` for one cycle. It sits directly upstream of the gate-level state/key datapath and owns all of that datapath's control; the datapath itself contains no sequential control.

## Interface
- NR, 10, number of rounds; legal range 2..10
- CK  in  1  clock; all state updates on rising edge
- RN  in  1  reset; asynchronous, active-low
- start  in  1  request to begin an encryption; sampled in IDLE and DONE only
- abort  in  1  synchronous cancel; returns to IDLE without `done`
- busy  out  1  high in LOAD and ROUND
- en  out  1  datapath state/key register enable; high in LOAD and ROUND
- load  out  1  selects plaintext XOR key into the state register; high in LOAD only
- key_load  out  1  selects external key into the key register; high in LOAD only
- round  out  4  current round index: 0 in IDLE/LOAD/DONE, 1..NR in ROUND
- rcon  out  8  round constant for the key expansion of the current round
- last_round  out  1  high in ROUND while round==NR; datapath bypasses MixColumns
- done  out  1  one-cycle pulse; ciphertext valid on datapath output during this cycle

## Operation
- States: IDLE, LOAD, ROUND, DONE. All outputs are registered or pure decodes of the state, round and rcon registers; there are no combinational paths from input to output.
- IDLE:
  - start=1 and abort=0 → LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly one cycle): load=key_load=en=busy=1, round=0, rcon=0x01.
  - Next state: ROUND with round=1.
  - abort=1 → IDLE.
- ROUND: en=busy=1. Each cycle: round increments by 1 and rcon advances by xtime: rcon_next = {rcon[6:0],0} ^ (rcon[7] ? 0x1B : 0x00).
  - rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
  - round==NR → DONE.
  - abort=1 → IDLE in every ROUND cycle.
- DONE (exactly one cycle): done=1, busy=en=0, round=0, rcon reloads 0x01.
  - start=1 and abort=0 → LOAD (back-to-back operation).
  - Otherwise → IDLE.
- start is ignored while in LOAD or ROUND; no request is queued.
- abort has priority over start in every state. An abort in DONE still leaves `done` high for that cycle, because `done` is already registered.
- round never exceeds NR and is never 0 while in ROUND.

## Timing
- Reset values while RN=0, applied asynchronously and immediately:
  - state=IDLE.
  - busy=en=load=key_load=last_round=done=0.
  - round=0, rcon=0x01.
- On RN deassertion, the first rising edge of CK evaluates IDLE.
- Reset mid-operation: all outputs return to reset values within the same cycle. No `done` is produced, and the datapath contents are don't-care.
- Latency:
  - start is sampled at edge E0.
  - LOAD occupies cycle E0→E1.
  - ROUND r occupies cycle Er→Er+1 for r = 1..NR.
  - DONE occupies cycle ENR+1→ENR+2.
  - `done` therefore goes high NR+1 cycles after the start edge: 11 for NR=10.
- Throughput with start held high continuously: one result every NR+2 cycles (12 for NR=10).
- en falls in the same cycle `done` rises, so the datapath holds the ciphertext stable during DONE and IDLE.

## Test plan
- Reset: hold RN=0 mid-ROUND (round=5) → all outputs immediately 0 except rcon=0x01. After release and an idle cycle, busy=0.
- Single run, NR=10, start pulsed for 1 cycle:
  - LOAD: load=key_load=1.
  - round steps 1..10 with rcon 01,02,04,08,10,20,40,80,1B,36.
  - last_round=1 only at round=10.
  - done=1 exactly 11 cycles after the start edge, for 1 cycle.
  - With the datapath attached, FIPS-197 vector (key 000102…0f, pt 00112233…ff) → ct 69c4e0d86a7b0430d8cdb78070b4c55a in the done cycle.
- Back-to-back: start held high for 30 cycles → done pulses at cycles 11 and 23, with LOAD directly following each DONE.
- start ignored: assert start during round 4 → no effect on the sequence, and exactly one done pulse.
- Abort:
  - abort in round 7 → IDLE next cycle, no done, round=0, rcon=0x01.
  - start=abort=1 in IDLE → stays IDLE.
- NR=2 parameter build → rounds 1,2 with rcon 01,02; last_round at round 2; done 3 cycles after start.
